jedro_1_regfile_sb: RTL and testbench

Parametrised integer register file with same-cycle write-to-read bypass, a per-register busy scoreboard for pending writebacks, and a configurable-depth destination/writeback delay line. It sits between decode (read ports, issue) and writeback (write port) of the jedro_1 core. It provides the hazard signal the decoder uses to stall, so forwarding and stall logic stay out of the pipeline stages.

---
 rtl/jedro_1_regfile_sb.sv | 111 +++++++++++
 tb/tb_jedro_1_regfile_sb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_regfile_sb.sv
// Integer register file with write-to-read bypass, per-register busy scoreboard
// for pending writebacks, and a fixed-depth dest/wb delay line.
module jedro_1_regfile_sb #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned REG_ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int unsigned BYPASS         = 1,
  parameter int unsigned WB_STAGES      = 1
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [REG_ADDR_WIDTH-1:0] rpa_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rpb_addr_i,
  input  logic                      rpa_en_i,
  input  logic                      rpb_en_i,
  output logic [DATA_WIDTH-1:0]     rpa_data_o,
  output logic [DATA_WIDTH-1:0]     rpb_data_o,
  output logic                      rpa_busy_o,
  output logic                      rpb_busy_o,
  output logic                      hazard_o,
  input  logic [REG_ADDR_WIDTH-1:0] wpc_addr_i,
  input  logic [DATA_WIDTH-1:0]     wpc_data_i,
  input  logic                      wpc_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] iss_addr_i,
  input  logic                      iss_valid_i,
  output logic                      waw_o,
  output logic [REG_ADDR_WIDTH:0]   pend_cnt_o,
  input  logic [REG_ADDR_WIDTH-1:0] reg_alu_dest_i,
  input  logic                      reg_alu_wb_i,
  output logic [REG_ADDR_WIDTH-1:0] reg_alu_dest_o,
  output logic                      reg_alu_wb_o
);

  logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]       busy_q, busy_d;
  logic [NUM_REGS-1:0]       clr, set;
  logic [REG_ADDR_WIDTH-1:0] dest_q [WB_STAGES];
  logic [WB_STAGES-1:0]      wb_q;

  // Storage; entry 0 is never written so it reads back as zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wpc_we_i && (wpc_addr_i != '0)) begin
      regs_q[wpc_addr_i] <= wpc_data_i;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [REG_ADDR_WIDTH-1:0] addr);
    if (addr == '0) return '0;
    if ((BYPASS != 0) && wpc_we_i && (wpc_addr_i == addr)) return wpc_data_i;
    return regs_q[addr];
  endfunction

  function automatic logic busy_port(input logic [REG_ADDR_WIDTH-1:0] addr);
    logic wr_hit;
    wr_hit = wpc_we_i && (wpc_addr_i == addr);
    if (BYPASS != 0) return busy_q[addr] & ~wr_hit;
    // Without forwarding the operand only becomes valid after the write lands.
    return busy_q[addr] | (wr_hit && (addr != '0));
  endfunction

  always_comb begin
    rpa_data_o = read_port(rpa_addr_i);
    rpb_data_o = read_port(rpb_addr_i);
    rpa_busy_o = busy_port(rpa_addr_i);
    rpb_busy_o = busy_port(rpb_addr_i);
    hazard_o   = (rpa_en_i & rpa_busy_o) | (rpb_en_i & rpb_busy_o);
    waw_o      = iss_valid_i & busy_q[iss_addr_i] & (iss_addr_i != '0);
  end

  // Set after clear so a same-cycle issue keeps the register pending.
  always_comb begin
    clr = '0;
    set = '0;
    if (wpc_we_i)    clr[wpc_addr_i] = 1'b1;
    if (iss_valid_i) set[iss_addr_i] = 1'b1;
    busy_d    = (busy_q & ~clr) | set;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  always_comb begin
    pend_cnt_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_cnt_o = pend_cnt_o + (REG_ADDR_WIDTH + 1)'(busy_q[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < WB_STAGES; i++) dest_q[i] <= '0;
      wb_q <= '0;
    end else begin
      dest_q[0] <= reg_alu_dest_i;
      wb_q[0]   <= reg_alu_wb_i;
      for (int i = 1; i < WB_STAGES; i++) begin
        dest_q[i] <= dest_q[i-1];
        wb_q[i]   <= wb_q[i-1];
      end
    end
  end

  assign reg_alu_dest_o = dest_q[WB_STAGES-1];
  assign reg_alu_wb_o   = wb_q[WB_STAGES-1];

endmodule

// File: tb/tb_jedro_1_regfile_sb.sv
// Directed bench: a forwarding instance (3-deep delay line) and a
// non-forwarding instance (1-deep delay line) share all inputs.
module tb_jedro_1_regfile_sb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  rpa_addr, rpb_addr, wpc_addr, iss_addr, dest_in;
  logic        rpa_en, rpb_en, wpc_we, iss_valid, wb_in;
  logic [31:0] wpc_data;

  logic [31:0] b_rda, b_rdb, n_rda, n_rdb;
  logic        b_bsa, b_bsb, b_haz, b_waw, b_wb;
  logic        n_bsa, n_bsb, n_haz, n_waw, n_wb;
  logic [5:0]  b_pend, n_pend;
  logic [4:0]  b_dest, n_dest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jedro_1_regfile_sb #(.BYPASS(1), .WB_STAGES(3)) dut_b (
    .clk_i(clk), .rstn_i(rstn),
    .rpa_addr_i(rpa_addr), .rpb_addr_i(rpb_addr), .rpa_en_i(rpa_en), .rpb_en_i(rpb_en),
    .rpa_data_o(b_rda), .rpb_data_o(b_rdb), .rpa_busy_o(b_bsa), .rpb_busy_o(b_bsb),
    .hazard_o(b_haz), .wpc_addr_i(wpc_addr), .wpc_data_i(wpc_data), .wpc_we_i(wpc_we),
    .iss_addr_i(iss_addr), .iss_valid_i(iss_valid), .waw_o(b_waw), .pend_cnt_o(b_pend),
    .reg_alu_dest_i(dest_in), .reg_alu_wb_i(wb_in),
    .reg_alu_dest_o(b_dest), .reg_alu_wb_o(b_wb)
  );

  jedro_1_regfile_sb #(.BYPASS(0), .WB_STAGES(1)) dut_n (
    .clk_i(clk), .rstn_i(rstn),
    .rpa_addr_i(rpa_addr), .rpb_addr_i(rpb_addr), .rpa_en_i(rpa_en), .rpb_en_i(rpb_en),
    .rpa_data_o(n_rda), .rpb_data_o(n_rdb), .rpa_busy_o(n_bsa), .rpb_busy_o(n_bsb),
    .hazard_o(n_haz), .wpc_addr_i(wpc_addr), .wpc_data_i(wpc_data), .wpc_we_i(wpc_we),
    .iss_addr_i(iss_addr), .iss_valid_i(iss_valid), .waw_o(n_waw), .pend_cnt_o(n_pend),
    .reg_alu_dest_i(dest_in), .reg_alu_wb_i(wb_in),
    .reg_alu_dest_o(n_dest), .reg_alu_wb_o(n_wb)
  );

  typedef struct {
    logic [4:0]  ra, rb;
    logic        ena, enb;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic [4:0]  ia;
    logic        iv;
    logic [31:0] x_rda, x_rdb;
    logic        x_bsa, x_bsb, x_haz, x_waw;
    logic [5:0]  x_pend;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rpa_addr = 0; rpb_addr = 0; rpa_en = 0; rpb_en = 0;
    wpc_addr = 0; wpc_data = 0; wpc_we = 0; iss_addr = 0; iss_valid = 0;
    dest_in = 0; wb_in = 0;
  endtask

  initial begin
    //          ra rb ena enb wa  wd            we ia iv  rda           rdb           bsa bsb haz waw pend
    vecs[0]  = '{5, 5, 0, 0, 5,  32'hDEADBEEF, 1, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0, 0};
    vecs[1]  = '{5, 5, 0, 0, 0,  32'h0,        0, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 5, 0, 0, 0,  32'h1234,     1, 0, 0,  32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0,  32'h0,        0, 0, 0,  32'h0,        32'h0,        0, 0, 0, 0, 0};
    vecs[4]  = '{7, 6, 0, 0, 7,  32'hA5A5A5A5, 1, 0, 0,  32'hA5A5A5A5, 32'h0,        0, 0, 0, 0, 0};
    vecs[5]  = '{3, 0, 1, 0, 0,  32'h0,        0, 3, 1,  32'h0,        32'h0,        0, 0, 0, 0, 0};
    vecs[6]  = '{3, 7, 1, 1, 0,  32'h0,        0, 0, 0,  32'h0,        32'hA5A5A5A5, 1, 0, 1, 0, 1};
    vecs[7]  = '{3, 0, 1, 0, 3,  32'h33,       1, 0, 0,  32'h33,       32'h0,        0, 0, 0, 0, 1};
    vecs[8]  = '{3, 0, 1, 0, 0,  32'h0,        0, 0, 0,  32'h33,       32'h0,        0, 0, 0, 0, 0};
    vecs[9]  = '{9, 0, 1, 0, 9,  32'h99,       1, 9, 1,  32'h99,       32'h0,        0, 0, 0, 0, 0};
    vecs[10] = '{9, 0, 1, 0, 0,  32'h0,        0, 0, 0,  32'h99,       32'h0,        1, 0, 1, 0, 1};
    vecs[11] = '{9, 0, 0, 0, 0,  32'h0,        0, 9, 1,  32'h99,       32'h0,        1, 0, 0, 1, 1};
    vecs[12] = '{9, 0, 0, 0, 0,  32'h0,        0, 0, 1,  32'h99,       32'h0,        1, 0, 0, 0, 1};
    vecs[13] = '{0, 9, 1, 1, 0,  32'h0,        0, 0, 0,  32'h0,        32'h99,       0, 1, 1, 0, 1};

    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rpa_addr = 5;
    #1;
    chk("reset_pend", 32'(b_pend), 0);
    chk("reset_dest", 32'(b_dest), 0);
    chk("reset_wb", 32'(b_wb), 0);
    chk("reset_rda", b_rda, 0);
    chk("reset_waw", 32'(b_waw), 0);
    rstn = 1'b1;
    step();

    foreach (vecs[k]) begin
      rpa_addr = vecs[k].ra; rpb_addr = vecs[k].rb; rpa_en = vecs[k].ena; rpb_en = vecs[k].enb;
      wpc_addr = vecs[k].wa; wpc_data = vecs[k].wd; wpc_we = vecs[k].we;
      iss_addr = vecs[k].ia; iss_valid = vecs[k].iv;
      #2;
      chk($sformatf("v%0d_rda", k), b_rda, vecs[k].x_rda);
      chk($sformatf("v%0d_rdb", k), b_rdb, vecs[k].x_rdb);
      chk($sformatf("v%0d_busya", k), 32'(b_bsa), 32'(vecs[k].x_bsa));
      chk($sformatf("v%0d_busyb", k), 32'(b_bsb), 32'(vecs[k].x_bsb));
      chk($sformatf("v%0d_hazard", k), 32'(b_haz), 32'(vecs[k].x_haz));
      chk($sformatf("v%0d_waw", k), 32'(b_waw), 32'(vecs[k].x_waw));
      chk($sformatf("v%0d_pend", k), 32'(b_pend), 32'(vecs[k].x_pend));
      step();
    end
    idle_inputs();

    // No-forward instance: a write in flight returns old data and reports busy.
    wpc_we = 1; wpc_addr = 7; wpc_data = 32'h12345678; rpa_addr = 7; rpa_en = 1;
    #2;
    chk("nobyp_old_data", n_rda, 32'hA5A5A5A5);
    chk("nobyp_busy", 32'(n_bsa), 1);
    chk("nobyp_hazard", 32'(n_haz), 1);
    chk("byp_new_data", b_rda, 32'h12345678);
    chk("byp_busy", 32'(b_bsa), 0);
    step();
    wpc_we = 0;
    #2;
    chk("nobyp_after_data", n_rda, 32'h12345678);
    chk("nobyp_after_busy", 32'(n_bsa), 0);
    wpc_we = 1; wpc_addr = 0; rpa_addr = 0;
    #2;
    chk("nobyp_x0_busy", 32'(n_bsa), 0);
    step();
    idle_inputs();

    // Delay line: one-cycle pulse.
    dest_in = 5'h11; wb_in = 1;
    step();
    dest_in = 0; wb_in = 0;
    chk("dl1_n_dest", 32'(n_dest), 32'h11);
    chk("dl1_n_wb", 32'(n_wb), 1);
    chk("dl1_b_dest", 32'(b_dest), 0);
    step();
    chk("dl2_n_dest", 32'(n_dest), 0);
    chk("dl2_b_wb", 32'(b_wb), 0);
    step();
    chk("dl3_b_dest", 32'(b_dest), 32'h11);
    chk("dl3_b_wb", 32'(b_wb), 1);
    step();
    chk("dl4_b_dest", 32'(b_dest), 0);
    chk("dl4_b_wb", 32'(b_wb), 0);

    // Async reset mid-cycle with x9 plus four more registers busy.
    for (int r = 0; r < 4; r++) begin
      iss_valid = 1; iss_addr = 5'(1 << r); dest_in = 5'h1F; wb_in = 1;
      step();
    end
    iss_valid = 0;
    rpa_addr = 5; rpb_addr = 7; rpa_en = 1; rpb_en = 1;
    #1;
    chk("pre_rst_pend", 32'(b_pend), 5);
    chk("pre_rst_dest", 32'(b_dest), 32'h1F);
    rstn = 1'b0;
    #1;
    chk("arst_pend", 32'(b_pend), 0);
    chk("arst_n_pend", 32'(n_pend), 0);
    chk("arst_dest", 32'(b_dest), 0);
    chk("arst_wb", 32'(b_wb), 0);
    chk("arst_n_wb", 32'(n_wb), 0);
    chk("arst_rda", b_rda, 0);
    chk("arst_rdb", b_rdb, 0);
    chk("arst_hazard", 32'(b_haz), 0);
    step();
    rstn = 1'b1;
    dest_in = 0; wb_in = 0;
    step();
    chk("post_rst_rda", b_rda, 0);
    chk("post_rst_pend", 32'(b_pend), 0);
    chk("post_rst_dest", 32'(b_dest), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
